mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Pipeline MEM stage, directly downstream of the EXE stage; consumes its ALU result, store data, control bits and destination.
- Drives a 16-bit external SRAM: each 32-bit word is two half-word accesses.
- Deasserts `ready` to freeze the whole pipeline while an access is in flight.
- Passes control/result fields combinationally to the MEM/WB register, like the EXE stage does.

Parameters:
- n, 32, datapath width
- SRAM_AW, 18, SRAM half-word address width
- ACC_CYCLES, 2, cycles per half-word SRAM access (1..15)
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- WB_EN_in  in  1  write-back enable from EXE
- MEM_R_EN_in  in  1  load request
- MEM_W_EN_in  in  1  store request
- ALU_res_in  in  n  byte address / ALU result
- Val_Rm_in  in  n  store data
- Dest_in  in  4  destination register
- WB_EN_out  out  1  = WB_EN_in
- MEM_R_EN_out  out  1  = MEM_R_EN_in
- ALU_res_out  out  n  = ALU_res_in
- Dest_out  out  4  = Dest_in
- Mem_res  out  n  loaded word (registered)
- ready  out  1  1 = stage may advance; 0 = freeze all pipeline registers and PC
- SRAM_ADDR  out  SRAM_AW  half-word address
- SRAM_DQ_out  out  16  write data
- SRAM_DQ_in  in  16  read data
- SRAM_DQ_oe  out  1  drive-enable for the DQ tristate
- SRAM_WE_N  out  1  active-low write strobe

Behaviour:
- Word index `w = (ALU_res_in - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits, so addresses wrap.
  - Low half is at `{w,0}` and carries bits [15:0]; high half is at `{w,1}` and carries bits [31:16].
- States: IDLE, LO, HI, DONE. Cycle counter cnt is `$clog2(ACC_CYCLES)+1` bits.
- IDLE:
  - `req = MEM_R_EN_in | MEM_W_EN_in`. `ready = ~req`, combinational.
  - If req: latch `op_wr = MEM_W_EN_in`, the word index, and Val_Rm_in. Go to LO with cnt=0.
  - Write has priority when both enables are set.
- LO / HI:
  - SRAM_ADDR is the respective half address. `ready=0`.
  - Write: `SRAM_DQ_oe=1`, SRAM_DQ_out = latched half, `SRAM_WE_N=0` for all but the last cycle of the phase. The last cycle has WE_N=1, giving data hold.
  - Read: `SRAM_DQ_oe=0`, `SRAM_WE_N=1`; SRAM_DQ_in is sampled into the lo/hi register on the last cycle (`cnt==ACC_CYCLES-1`).
  - Phase advance: LO→HI→DONE, with cnt cleared at each phase change.
- DONE:
  - `ready=1` for exactly one cycle, so the pipeline advances at this edge. Next state is IDLE.
  - On a read, `Mem_res <= {hi,lo}` at entry to DONE. Mem_res holds its value until the next completed read; stores leave it unchanged.
- Latency: `ready` is low for 1 + 2*ACC_CYCLES cycles (5 at default), then high for 1 cycle.
- Back-to-back memory ops: the new request is seen in the IDLE cycle after DONE. There is no lost and no duplicated access.
- Inputs are assumed stable while ready=0; this is guaranteed by the freeze.
- Reset (any time, including mid-access):
  - state=IDLE, cnt=0, Mem_res=0, lo/hi=0.
  - `SRAM_WE_N=1` and `SRAM_DQ_oe=0` immediately, asynchronously. SRAM_ADDR=0, SRAM_DQ_out=0.
  - ready follows the IDLE rule.
- Idle outputs: SRAM_ADDR=0, SRAM_DQ_out=0, WE_N=1, oe=0.

Optional Feature:
- Macro MEM_ADDR_CHECK_EN.
- With the macro defined:
  - Adds output `addr_err` (1 bit).
  - A request with `ALU_res_in < BASE_ADDR`, or `w >= 2^(SRAM_AW-1)`, or `ALU_res_in[1:0] != 0`:
    - skips the SRAM entirely and goes IDLE→DONE, so ready is low 1 cycle;
    - on a read, loads Mem_res=0;
    - asserts addr_err=1 for the DONE cycle only.
- Without the macro: no port and no check; addresses wrap as above.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, LO, HI, DONE};
  - SRAM data width constant (16);
  - default BASE_ADDR.
- Sub-module sram_controller holds the FSM, counter, lo/hi capture and SRAM pins.
- mem_stage_sram is the wrapper: pass-through assigns, address computation, optional range check.

Test Plan:
- Reset mid-store: rst during LO → SRAM_WE_N=1, oe=0 the same cycle; ready=1 after release; Mem_res=0.
- Store 0xDEADBEEF at 1032 (w=2), then load 1032:
  - store drives ADDR 4 with DQ 0xBEEF, then ADDR 5 with DQ 0xDEAD; WE_N low 1 cycle per phase;
  - load returns Mem_res=0xDEADBEEF;
  - each op has ready low exactly 5 cycles.
- Both enables set, address 1024, Val_Rm=0x12345678: write performed (ADDR 0←0x5678, ADDR 1←0x1234); Mem_res unchanged.
- Back-to-back loads at 1024 and 1028 with SRAM model: two separate 5-low/1-high ready windows; Mem_res=word0 then word1; no duplicate SRAM access.
- Non-memory instruction (WB_EN=1, both mem enables 0): ready stays 1; outputs equal inputs the same cycle; SRAM pins idle.
- MEM_ADDR_CHECK_EN, load at 1000: no SRAM activity; ready low 1 cycle; addr_err=1 in DONE; Mem_res=0.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// mem_pkg: shared types and constants for the MEM stage / SRAM controller.
//   state_e           : controller phase (IDLE, LO half, HI half, DONE)
//   SRAM_DW           : external SRAM data width (one half-word)
//   DEFAULT_BASE_ADDR : byte address that maps to SRAM half-word 0
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SRAM_DW           = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage : mem_pkg

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if: pin bundle of the 16-bit external SRAM.
//   SRAM_ADDR   : half-word address           (master -> slave)
//   SRAM_DQ_out : write data                   (master -> slave)
//   SRAM_DQ_oe  : drive-enable of DQ tristate  (master -> slave)
//   SRAM_WE_N   : active-low write strobe      (master -> slave)
//   SRAM_DQ_in  : read data                    (slave  -> master)
interface mem_stage_sram_if #(
  parameter int SRAM_AW = 18
) ();
  import mem_pkg::*;

  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [SRAM_DW-1:0] SRAM_DQ_out;
  logic [SRAM_DW-1:0] SRAM_DQ_in;
  logic               SRAM_DQ_oe;
  logic               SRAM_WE_N;

  modport master (
    output SRAM_ADDR,
    output SRAM_DQ_out,
    output SRAM_DQ_oe,
    output SRAM_WE_N,
    input  SRAM_DQ_in
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_DQ_out,
    input  SRAM_DQ_oe,
    input  SRAM_WE_N,
    output SRAM_DQ_in
  );

endinterface : mem_stage_sram_if

// File: rtl/mem_stage_sram_ctrl.sv
// sram_controller: splits one 32-bit load/store into two half-word SRAM
// accesses (low half first) and holds the pipeline frozen meanwhile.
//   clk, rst         : clock, asynchronous active-high reset
//   rd_en_i, wr_en_i : load / store request (store wins if both set)
//   word_i           : word index (already offset and truncated)
//   wdata_i          : store data
//   skip_i           : (MEM_ADDR_CHECK_EN only) bad address, bypass SRAM
//   addr_err_o       : (MEM_ADDR_CHECK_EN only) high in DONE of a skipped op
//   ready_o          : 1 = pipeline may advance
//   mem_res_o        : last loaded word
//   sram             : SRAM pins (master side)
// Optional feature macro: MEM_ADDR_CHECK_EN.
module sram_controller import mem_pkg::*; #(
  parameter int SRAM_AW    = 18,
  parameter int ACC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [SRAM_AW-2:0]   word_i,
  input  logic [2*SRAM_DW-1:0] wdata_i,
`ifdef MEM_ADDR_CHECK_EN
  input  logic                 skip_i,
  output logic                 addr_err_o,
`endif
  output logic                 ready_o,
  output logic [2*SRAM_DW-1:0] mem_res_o,
  mem_stage_sram_if.master     sram
);

  localparam int             CW       = $clog2(ACC_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(ACC_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q;
  logic [SRAM_AW-2:0]   word_q;
  logic [2*SRAM_DW-1:0] wdata_q;
  logic [SRAM_DW-1:0]   lo_q;
  // The high half is captured straight into mem_res_q[31:16].
  logic [2*SRAM_DW-1:0] mem_res_q;

  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   dq_q, dq_d;
  logic                 oe_q, oe_d;
  logic                 we_n_q, we_n_d;

  logic                 req_s;
  logic                 last_s;
  logic                 wr_now_s;
  logic [SRAM_AW-2:0]   word_now_s;
  logic [2*SRAM_DW-1:0] wdata_now_s;

`ifdef MEM_ADDR_CHECK_EN
  logic                 err_q;
`endif

  assign req_s  = rd_en_i | wr_en_i;
  assign last_s = (cnt_q == CNT_LAST);

  // IDLE is the only state whose ready depends on the live request.
  assign ready_o = (state_q == IDLE) ? ~req_s : (state_q == DONE);

  // Operation attributes: live inputs while accepting, latched copy after.
  always_comb begin
    wr_now_s    = op_wr_q;
    word_now_s  = word_q;
    wdata_now_s = wdata_q;
    if (state_q == IDLE) begin
      wr_now_s    = wr_en_i;
      word_now_s  = word_i;
      wdata_now_s = wdata_i;
    end else begin
      wr_now_s    = op_wr_q;
      word_now_s  = word_q;
      wdata_now_s = wdata_q;
    end
  end

  // Next state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (req_s) begin
`ifdef MEM_ADDR_CHECK_EN
          state_d = skip_i ? DONE : LO;
`else
          state_d = LO;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (last_s) begin
          state_d = HI;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = LO;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      HI: begin
        if (last_s) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = HI;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // SRAM pin values for the state being entered; WE_N rises on the final
  // cycle of each write phase so data is held past the strobe edge.
  always_comb begin
    addr_d = {SRAM_AW{1'b0}};
    dq_d   = {SRAM_DW{1'b0}};
    oe_d   = 1'b0;
    we_n_d = 1'b1;
    case (state_d)
      LO: begin
        addr_d = {word_now_s, 1'b0};
        oe_d   = wr_now_s;
        dq_d   = wr_now_s ? wdata_now_s[SRAM_DW-1:0] : {SRAM_DW{1'b0}};
        we_n_d = ~(wr_now_s & (cnt_d != CNT_LAST));
      end
      HI: begin
        addr_d = {word_now_s, 1'b1};
        oe_d   = wr_now_s;
        dq_d   = wr_now_s ? wdata_now_s[2*SRAM_DW-1:SRAM_DW] : {SRAM_DW{1'b0}};
        we_n_d = ~(wr_now_s & (cnt_d != CNT_LAST));
      end
      default: begin
        addr_d = {SRAM_AW{1'b0}};
        dq_d   = {SRAM_DW{1'b0}};
        oe_d   = 1'b0;
        we_n_d = 1'b1;
      end
    endcase
  end

  // FSM state, operation latch, read capture and registered SRAM pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      op_wr_q   <= 1'b0;
      word_q    <= {(SRAM_AW-1){1'b0}};
      wdata_q   <= {(2*SRAM_DW){1'b0}};
      lo_q      <= {SRAM_DW{1'b0}};
      mem_res_q <= {(2*SRAM_DW){1'b0}};
      addr_q    <= {SRAM_AW{1'b0}};
      dq_q      <= {SRAM_DW{1'b0}};
      oe_q      <= 1'b0;
      we_n_q    <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      if ((state_q == IDLE) && req_s) begin
        op_wr_q <= wr_en_i;
        word_q  <= word_i;
        wdata_q <= wdata_i;
      end
      if ((state_q == LO) && last_s && !op_wr_q) begin
        lo_q <= sram.SRAM_DQ_in;
      end
      if ((state_q == HI) && last_s && !op_wr_q) begin
        mem_res_q <= {sram.SRAM_DQ_in, lo_q};
      end
`ifdef MEM_ADDR_CHECK_EN
      err_q <= (state_q == IDLE) && req_s && skip_i;
      if ((state_q == IDLE) && req_s && skip_i && !wr_en_i) begin
        mem_res_q <= {(2*SRAM_DW){1'b0}};
      end
`endif
    end
  end

  assign mem_res_o        = mem_res_q;
  assign sram.SRAM_ADDR   = addr_q;
  assign sram.SRAM_DQ_out = dq_q;
  assign sram.SRAM_DQ_oe  = oe_q;
  assign sram.SRAM_WE_N   = we_n_q;
`ifdef MEM_ADDR_CHECK_EN
  assign addr_err_o       = err_q;
`endif

endmodule : sram_controller

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline MEM stage backed by a 16-bit external SRAM.
//   clk, rst        : clock, asynchronous active-high reset
//   WB_EN_in/out, MEM_R_EN_in/out, ALU_res_in/out, Dest_in/out :
//                     pass-through to the MEM/WB register (combinational)
//   MEM_W_EN_in     : store request; Val_Rm_in : store data
//   Mem_res         : loaded word (registered)
//   ready           : 0 freezes all pipeline registers and the PC
//   sram            : SRAM pins (master modport)
//   addr_err        : (MEM_ADDR_CHECK_EN only) out-of-range/misaligned access
// Optional feature macro: MEM_ADDR_CHECK_EN.
module mem_stage_sram import mem_pkg::*; #(
  parameter int n          = 32,
  parameter int SRAM_AW    = 18,
  parameter int ACC_CYCLES = 2,
  parameter int BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB_EN_in,
  input  logic             MEM_R_EN_in,
  input  logic             MEM_W_EN_in,
  input  logic [n-1:0]     ALU_res_in,
  input  logic [n-1:0]     Val_Rm_in,
  input  logic [3:0]       Dest_in,
  output logic             WB_EN_out,
  output logic             MEM_R_EN_out,
  output logic [n-1:0]     ALU_res_out,
  output logic [3:0]       Dest_out,
  output logic [n-1:0]     Mem_res,
  output logic             ready,
`ifdef MEM_ADDR_CHECK_EN
  output logic             addr_err,
`endif
  mem_stage_sram_if.master sram
);

  logic [n-1:0]         offs_s;
  logic [SRAM_AW-2:0]   word_s;
  logic [2*SRAM_DW-1:0] mem_res_s;
  logic                 unused_offs_s;

  assign WB_EN_out    = WB_EN_in;
  assign MEM_R_EN_out = MEM_R_EN_in;
  assign ALU_res_out  = ALU_res_in;
  assign Dest_out     = Dest_in;

  // Byte offset into SRAM; keeping SRAM_AW-1 word bits makes addresses wrap.
  assign offs_s = ALU_res_in - n'(BASE_ADDR);
  assign word_s = offs_s[SRAM_AW:2];

`ifdef MEM_ADDR_CHECK_EN
  logic bad_s;
  // Below base, beyond the SRAM (any dropped word bit set), or misaligned.
  assign bad_s = (ALU_res_in < n'(BASE_ADDR))
               | (|offs_s[n-1:SRAM_AW+1])
               | (|ALU_res_in[1:0]);
  assign unused_offs_s = ^offs_s[1:0];
`else
  assign unused_offs_s = ^{offs_s[n-1:SRAM_AW+1], offs_s[1:0]};
`endif

  sram_controller #(
    .SRAM_AW    (SRAM_AW),
    .ACC_CYCLES (ACC_CYCLES)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (MEM_R_EN_in),
    .wr_en_i    (MEM_W_EN_in),
    .word_i     (word_s),
    .wdata_i    (Val_Rm_in),
`ifdef MEM_ADDR_CHECK_EN
    .skip_i     (bad_s),
    .addr_err_o (addr_err),
`endif
    .ready_o    (ready),
    .mem_res_o  (mem_res_s),
    .sram       (sram)
  );

  assign Mem_res = mem_res_s;

endmodule : mem_stage_sram

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;
  import mem_pkg::*;

  localparam int AW = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_res_in, Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN_out, MEM_R_EN_out;
  logic [31:0] ALU_res_out, Mem_res;
  logic [3:0]  Dest_out;
  logic        ready;
`ifdef MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [33:0] wlog[$];
  int          addr_hits [0:63];
  int          act_cycles = 0;
  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  mem_stage_sram_if #(.SRAM_AW(AW)) sram ();

  mem_stage_sram dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .ALU_res_in   (ALU_res_in),
    .Val_Rm_in    (Val_Rm_in),
    .Dest_in      (Dest_in),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_res_out  (ALU_res_out),
    .Dest_out     (Dest_out),
    .Mem_res      (Mem_res),
    .ready        (ready),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err     (addr_err),
`endif
    .sram         (sram)
  );

  // SRAM model: asynchronous read, write sampled mid-cycle while WE_N low.
  assign sram.SRAM_DQ_in = sram.SRAM_DQ_oe ? 16'h0000 : mem[sram.SRAM_ADDR[5:0]];

  // SRAM model storage plus activity monitor.
  always @(negedge clk) begin
    if (rst) begin
      mem[2] <= 16'hCAFE;
      mem[3] <= 16'hF00D;
    end
    if (!sram.SRAM_WE_N) begin
      mem[sram.SRAM_ADDR[5:0]] <= sram.SRAM_DQ_out;
      wlog.push_back({sram.SRAM_ADDR, sram.SRAM_DQ_out});
    end
    if (!sram.SRAM_DQ_oe && sram.SRAM_WE_N)
      addr_hits[sram.SRAM_ADDR[5:0]] <= addr_hits[sram.SRAM_ADDR[5:0]] + 1;
    if ((sram.SRAM_ADDR != 18'd0) || sram.SRAM_DQ_oe || !sram.SRAM_WE_N)
      act_cycles <= act_cycles + 1;
  end

  task automatic clear_inputs();
    WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_res_in = 32'd0; Val_Rm_in = 32'd0; Dest_in = 4'd0;
  endtask

  // Issue one memory op (called #1 after a posedge); returns #1 after the
  // edge that leaves DONE.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input int exp_low,
                       input logic exp_err, input string name);
    int   low;
    logic done;
    logic [31:0] exp;
    WB_EN_in = rd; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
    ALU_res_in = addr; Val_Rm_in = data; Dest_in = 4'd3;
    low = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else low++;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s_timeout: ready never returned high", name);
    end
    n_checks++;
    if (low !== exp_low) begin
      n_fail++; $display("FAIL %s_ready_low: got %0d cycles, want %0d", name, low, exp_low);
    end
    if (rd && !wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s_scoreboard: no expected value queued", name);
      end else begin
        exp = exp_q.pop_front();
        if (Mem_res !== exp) begin
          n_fail++; $display("FAIL %s_mem_res: got %h, want %h", name, Mem_res, exp);
        end
      end
    end
`ifdef MEM_ADDR_CHECK_EN
    n_checks++;
    if (addr_err !== exp_err) begin
      n_fail++; $display("FAIL %s_addr_err: got %b, want %b", name, addr_err, exp_err);
    end
`else
    if (exp_err) $display("note: %s expects addr_err but the check is not built", name);
`endif
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || Mem_res !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: ready=%b Mem_res=%h, want 1/0", ready, Mem_res);
    end
    n_checks++;
    if (sram.SRAM_WE_N !== 1'b1 || sram.SRAM_DQ_oe !== 1'b0 || sram.SRAM_ADDR !== 18'd0
        || sram.SRAM_DQ_out !== 16'd0) begin
      n_fail++; $display("FAIL reset_pins: we_n=%b oe=%b addr=%h dq=%h", sram.SRAM_WE_N,
                         sram.SRAM_DQ_oe, sram.SRAM_ADDR, sram.SRAM_DQ_out);
    end
    rst = 1'b0;
    // Start a store, then reset in the middle of its LO phase.
    MEM_W_EN_in = 1'b1; ALU_res_in = 32'd1032; Val_Rm_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    n_checks++;
    if (sram.SRAM_WE_N !== 1'b0 || sram.SRAM_DQ_oe !== 1'b1) begin
      n_fail++; $display("FAIL midstore_active: we_n=%b oe=%b, want 0/1", sram.SRAM_WE_N, sram.SRAM_DQ_oe);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (sram.SRAM_WE_N !== 1'b1 || sram.SRAM_DQ_oe !== 1'b0) begin
      n_fail++; $display("FAIL midstore_reset_pins: we_n=%b oe=%b, want 1/0", sram.SRAM_WE_N, sram.SRAM_DQ_oe);
    end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || Mem_res !== 32'd0) begin
      n_fail++; $display("FAIL midstore_release: ready=%b Mem_res=%h, want 1/0", ready, Mem_res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int w0;
    w0 = wlog.size();
    do_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 5, 1'b0, "store1032");
    n_checks++;
    if (wlog.size() - w0 != 2) begin
      n_fail++; $display("FAIL store_strobes: got %0d WE_N-low cycles, want 2", wlog.size() - w0);
    end else begin
      n_checks++;
      if (wlog[w0] !== {18'd4, 16'hBEEF} || wlog[w0+1] !== {18'd5, 16'hDEAD}) begin
        n_fail++; $display("FAIL store_trace: got %h %h, want 4:BEEF 5:DEAD", wlog[w0], wlog[w0+1]);
      end
    end
    exp_q.push_back(32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'd1032, 32'd0, 5, 1'b0, "load1032");
  endtask

  task automatic test_both_enables();
    int w0;
    w0 = wlog.size();
    do_op(1'b1, 1'b1, 32'd1024, 32'h12345678, 5, 1'b0, "both1024");
    n_checks++;
    if (wlog.size() - w0 != 2) begin
      n_fail++; $display("FAIL both_strobes: got %0d, want 2", wlog.size() - w0);
    end else begin
      n_checks++;
      if (wlog[w0] !== {18'd0, 16'h5678} || wlog[w0+1] !== {18'd1, 16'h1234}) begin
        n_fail++; $display("FAIL both_trace: got %h %h, want 0:5678 1:1234", wlog[w0], wlog[w0+1]);
      end
    end
    n_checks++;
    if (Mem_res !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL both_mem_res_kept: got %h, want deadbeef", Mem_res);
    end
  endtask

  task automatic test_back_to_back();
    int h1, h2, h3, w0;
    h1 = addr_hits[1]; h2 = addr_hits[2]; h3 = addr_hits[3]; w0 = wlog.size();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hF00DCAFE);
    do_op(1'b1, 1'b0, 32'd1024, 32'd0, 5, 1'b0, "b2b_load0");
    do_op(1'b1, 1'b0, 32'd1028, 32'd0, 5, 1'b0, "b2b_load1");
    n_checks++;
    if (addr_hits[1] - h1 != 2 || addr_hits[2] - h2 != 2 || addr_hits[3] - h3 != 2) begin
      n_fail++; $display("FAIL b2b_accesses: addr1/2/3 cycles %0d/%0d/%0d, want 2/2/2",
                         addr_hits[1] - h1, addr_hits[2] - h2, addr_hits[3] - h3);
    end
    n_checks++;
    if (wlog.size() != w0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_side_effects: writes=%0d pending=%0d, want 0/0",
                         wlog.size() - w0, exp_q.size());
    end
  endtask

  task automatic test_passthrough();
    int a0;
    a0 = act_cycles;
    WB_EN_in = 1'b1; ALU_res_in = 32'h0000ABCD; Dest_in = 4'hA; Val_Rm_in = 32'h55AA55AA;
    #1;
    n_checks++;
    if (WB_EN_out !== 1'b1 || MEM_R_EN_out !== 1'b0 || ALU_res_out !== 32'h0000ABCD
        || Dest_out !== 4'hA || ready !== 1'b1) begin
      n_fail++; $display("FAIL pass_outputs: wb=%b rd=%b alu=%h dest=%h ready=%b",
                         WB_EN_out, MEM_R_EN_out, ALU_res_out, Dest_out, ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ALU_res_in = 32'h1000 + 32'(i); Dest_in = 4'(i);
      #1;
      n_checks++;
      if (ready !== 1'b1 || ALU_res_out !== 32'h1000 + 32'(i) || Dest_out !== 4'(i)) begin
        n_fail++; $display("FAIL pass_cycle%0d: ready=%b alu=%h dest=%h", i, ready, ALU_res_out, Dest_out);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (act_cycles != a0) begin
      n_fail++; $display("FAIL pass_sram_idle: %0d active SRAM cycles, want 0", act_cycles - a0);
    end
    clear_inputs();
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic test_addr_err();
    int a0;
    a0 = act_cycles;
    exp_q.push_back(32'd0);
    do_op(1'b1, 1'b0, 32'd1000, 32'd0, 1, 1'b1, "err_load1000");
    n_checks++;
    if (act_cycles != a0) begin
      n_fail++; $display("FAIL err_sram_idle: %0d active SRAM cycles, want 0", act_cycles - a0);
    end
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: addr_err=%b after DONE, want 0", addr_err);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_both_enables();
    test_back_to_back();
    test_passthrough();
`ifdef MEM_ADDR_CHECK_EN
    test_addr_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_stage_sram
